mac_operand_feeder: RTL and testbench

- Producer side of the MAC operand interface.
- Holds two small signed operand vectors (bank A, bank B), loaded through a simple write port.
- On `start`, streams element pairs to a MAC unit on independent `valid_a`/`valid_b` strobes, optionally skewed so either operand leads.
- After the last element it waits a fixed latency, then captures the MAC accumulator as the dot-product result.

---
 rtl/mac_operand_feeder.sv | 241 ++++++++++++++++++++++++
 tb/tb_mac_operand_feeder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// Producer side of a MAC operand interface: streams two signed operand banks with optional skew,
// then captures the MAC accumulator. Define MAC_FEEDER_CHECK_EN for the self-check accumulator.
module mac_operand_feeder #(
    parameter int unsigned DW          = 4,
    parameter int unsigned ACC_W       = 11,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned CAPTURE_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic [1:0]        skew_mode,
    input  logic              start,
    output logic              busy,
    output logic [DW-1:0]     out_a,
    output logic              out_valid_a,
    output logic [DW-1:0]     out_b,
    output logic              out_valid_b,
    input  logic [ACC_W-1:0]  mac_result,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid
`ifdef MAC_FEEDER_CHECK_EN
    ,
    output logic              mismatch
`endif
);

    localparam int unsigned LatW = (CAPTURE_LAT > 1) ? $clog2(CAPTURE_LAT) : 1;
    localparam logic [ADDR_W:0] LenMax = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] KOne = (ADDR_W+1)'(1);
    localparam logic [LatW-1:0] LatOne = LatW'(1);
    localparam logic [LatW-1:0] LatLast = LatW'(CAPTURE_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     k_q, k_d, len_q, len_d;
    logic [1:0]          skew_q, skew_d;
    logic                phase_q, phase_d;
    logic [LatW-1:0]     lat_q, lat_d;
    logic                busy_q, busy_d, va_q, va_d, vb_q, vb_d, rv_q, rv_d;
    logic [DW-1:0]       oa_q, oa_d, ob_q, ob_d;
    logic [ACC_W-1:0]    res_q, res_d;
    logic [DW-1:0]       bank_a_q [DEPTH];
    logic [DW-1:0]       bank_b_q [DEPTH];

    logic                em_en, em_phase;
    logic [ADDR_W-1:0]   em_idx;
    logic [1:0]          em_skew, skew_norm;
    logic [DW-1:0]       a_rd, b_rd;
    logic [ADDR_W:0]     len_clamp, k_next;
    logic                wr_ok;
`ifdef MAC_FEEDER_CHECK_EN
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                mis_q, mis_d;
    logic signed [2*DW-1:0] prod;
`endif

    assign wr_ok     = wr_en && (state_q == StIdle);
    assign skew_norm = (skew_mode == 2'b11) ? 2'b00 : skew_mode;
    assign len_clamp = (len > LenMax) ? LenMax : len;
    assign k_next    = k_q + KOne;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        len_d    = len_q;
        skew_d   = skew_q;
        phase_d  = phase_q;
        lat_d    = lat_q;
        busy_d   = busy_q;
        res_d    = res_q;
        va_d     = 1'b0;
        vb_d     = 1'b0;
        oa_d     = '0;
        ob_d     = '0;
        rv_d     = 1'b0;
        em_en    = 1'b0;
        em_phase = 1'b0;
        em_idx   = '0;
        em_skew  = skew_q;
        a_rd     = '0;
        b_rd     = '0;
`ifdef MAC_FEEDER_CHECK_EN
        acc_d    = acc_q;
        mis_d    = mis_q;
        prod     = '0;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = len_clamp;
                    skew_d  = skew_norm;
                    k_d     = '0;
                    phase_d = 1'b0;
                    busy_d  = 1'b1;
`ifdef MAC_FEEDER_CHECK_EN
                    acc_d   = '0;
                    mis_d   = 1'b0;
`endif
                    if (len_clamp == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        em_en   = 1'b1;
                        em_skew = skew_norm;
                    end
                end
            end
            StIssue: begin
                // Element finishes on its only cycle (paired) or on its second half (skewed)
                if ((skew_q == 2'b00) || phase_q) begin
                    if (k_next == len_q) begin
                        state_d = StDrain;
                        lat_d   = '0;
                    end else begin
                        k_d     = k_next;
                        phase_d = 1'b0;
                        em_en   = 1'b1;
                        em_idx  = k_next[ADDR_W-1:0];
                    end
                end else begin
                    phase_d  = 1'b1;
                    em_en    = 1'b1;
                    em_phase = 1'b1;
                    em_idx   = k_q[ADDR_W-1:0];
                end
            end
            StDrain: begin
                if (lat_q == LatLast) begin
                    state_d = StDone;
                end else begin
                    lat_d = lat_q + LatOne;
                end
            end
            StDone: begin
                res_d   = (len_q == '0) ? '0 : mac_result;
                rv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
`ifdef MAC_FEEDER_CHECK_EN
                mis_d   = mis_q | (acc_q != res_d);
`endif
            end
            default: state_d = StIdle;
        endcase

        if (em_en) begin
            // A write in the start cycle is forwarded so the run sees the new value
            a_rd = (wr_ok && !wr_sel && (wr_addr == em_idx)) ? wr_data : bank_a_q[em_idx];
            b_rd = (wr_ok && wr_sel && (wr_addr == em_idx)) ? wr_data : bank_b_q[em_idx];
            case (em_skew)
                2'b01: begin
                    if (!em_phase) begin va_d = 1'b1; oa_d = a_rd; end
                    else begin vb_d = 1'b1; ob_d = b_rd; end
                end
                2'b10: begin
                    if (!em_phase) begin vb_d = 1'b1; ob_d = b_rd; end
                    else begin va_d = 1'b1; oa_d = a_rd; end
                end
                default: begin
                    va_d = 1'b1;
                    vb_d = 1'b1;
                    oa_d = a_rd;
                    ob_d = b_rd;
                end
            endcase
`ifdef MAC_FEEDER_CHECK_EN
            if (!em_phase) begin
                prod  = $signed(a_rd) * $signed(b_rd);
                acc_d = acc_d + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            len_q   <= '0;
            skew_q  <= '0;
            phase_q <= 1'b0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            va_q    <= 1'b0;
            vb_q    <= 1'b0;
            oa_q    <= '0;
            ob_q    <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
`ifdef MAC_FEEDER_CHECK_EN
            acc_q   <= '0;
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            skew_q  <= skew_d;
            phase_q <= phase_d;
            lat_q   <= lat_d;
            busy_q  <= busy_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
            oa_q    <= oa_d;
            ob_q    <= ob_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
`ifdef MAC_FEEDER_CHECK_EN
            acc_q   <= acc_d;
            mis_q   <= mis_d;
`endif
        end
    end

    // Bank storage is deliberately not reset so data survives an aborted run
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (wr_sel) bank_b_q[wr_addr] <= wr_data;
            else        bank_a_q[wr_addr] <= wr_data;
        end
    end

    assign busy         = busy_q;
    assign out_a        = oa_q;
    assign out_b        = ob_q;
    assign out_valid_a  = va_q;
    assign out_valid_b  = vb_q;
    assign result       = res_q;
    assign result_valid = rv_q;
`ifdef MAC_FEEDER_CHECK_EN
    assign mismatch     = mis_q;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder with a loopback MAC model on the operand strobes.
module tb_mac_operand_feeder;

    typedef struct packed {
        int         cyc;
        logic       va;
        logic       vb;
        logic [3:0] a;
        logic [3:0] b;
    } strobe_t;

    logic        clk, reset, wr_en, wr_sel, start, busy, va, vb, rv;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_data, len, out_a, out_b;
    logic [1:0]  skew_mode;
    logic [10:0] mac_result, result;
    logic        mac_clr, mac_force;
`ifdef MAC_FEEDER_CHECK_EN
    logic        mismatch;
`endif

    int checks = 0;
    int errors = 0;
    int ma [8];
    int mb [8];
    strobe_t     exp_q [$];
    logic [10:0] exp_res_q [$];
    int          exp_rv_q [$];

    mac_operand_feeder dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .len(len), .skew_mode(skew_mode), .start(start), .busy(busy),
        .out_a(out_a), .out_valid_a(va), .out_b(out_b), .out_valid_b(vb),
        .mac_result(mac_result), .result(result), .result_valid(rv)
`ifdef MAC_FEEDER_CHECK_EN
        , .mismatch(mismatch)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback MAC: holds whichever operand arrives first, accumulates once both are present
    logic signed [10:0] m_acc, m_prod;
    logic signed [3:0]  m_pa, m_pb, m_av, m_bv;
    logic               m_ha, m_hb, m_na, m_nb;
    always_comb begin
        m_na   = m_ha | va;
        m_nb   = m_hb | vb;
        m_av   = va ? $signed(out_a) : m_pa;
        m_bv   = vb ? $signed(out_b) : m_pb;
        m_prod = m_av * m_bv;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset || mac_clr) begin
            m_acc <= '0; m_ha <= 1'b0; m_hb <= 1'b0; m_pa <= '0; m_pb <= '0;
        end else if (m_na && m_nb) begin
            m_acc <= m_acc + m_prod; m_ha <= 1'b0; m_hb <= 1'b0;
        end else begin
            m_ha <= m_na; m_hb <= m_nb; m_pa <= m_av; m_pb <= m_bv;
        end
    end
    assign mac_result = mac_force ? 11'd5 : m_acc;

    task automatic load(input logic sel, input int addr, input int data);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr[2:0]; wr_data = data[3:0];
        if (sel) mb[addr] = data; else ma[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic push_expected(input int n_in, input logic [1:0] sk);
        int n, s, issue;
        logic [3:0] a4, b4;
        n = (n_in > 8) ? 8 : n_in;
        s = 0;
        for (int j = 0; j < n; j++) begin
            a4 = ma[j][3:0];
            b4 = mb[j][3:0];
            s += ma[j] * mb[j];
            if (sk == 2'b01) begin
                exp_q.push_back('{1 + 2*j, 1'b1, 1'b0, a4, 4'h0});
                exp_q.push_back('{2 + 2*j, 1'b0, 1'b1, 4'h0, b4});
            end else if (sk == 2'b10) begin
                exp_q.push_back('{1 + 2*j, 1'b0, 1'b1, 4'h0, b4});
                exp_q.push_back('{2 + 2*j, 1'b1, 1'b0, a4, 4'h0});
            end else begin
                exp_q.push_back('{1 + j, 1'b1, 1'b1, a4, b4});
            end
        end
        issue = (sk == 2'b01 || sk == 2'b10) ? 2*n : n;
        exp_res_q.push_back(s[10:0]);
        exp_rv_q.push_back((n == 0) ? 2 : 1 + issue + 2 + 1);
    endtask

    // Drives one start and scores every strobe and result pulse in a fixed 24-cycle window
    task automatic run(input string name, input int n, input logic [1:0] sk, input int inj,
                       input bit wr0, input int wr0_data);
        strobe_t o, e;
        int rv_count, zero_viol, ecyc;
        logic [10:0] eres;
        rv_count = 0;
        zero_viol = 0;
        @(negedge clk);
        len = n[3:0]; skew_mode = sk; start = 1'b1; mac_clr = 1'b1;
        if (wr0) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd0; wr_data = wr0_data[3:0];
        end
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0; mac_clr = 1'b0;
            if (i == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_after_start got %b want 1", name, busy);
                end
            end
            if ((!va && out_a !== 4'h0) || (!vb && out_b !== 4'h0)) zero_viol++;
            if (va || vb) begin
                o = '{i, va, vb, va ? out_a : 4'h0, vb ? out_b : 4'h0};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_strobe cyc %0d va %b vb %b", name, i, va, vb);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL %s strobe got cyc%0d va%b vb%b a%h b%h want cyc%0d va%b vb%b a%h b%h",
                                 name, o.cyc, o.va, o.vb, o.a, o.b, e.cyc, e.va, e.vb, e.a, e.b);
                    end
                end
            end
            if (rv) begin
                rv_count++;
                checks++;
                if (exp_res_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_result_valid cyc %0d", name, i);
                end else begin
                    eres = exp_res_q.pop_front();
                    ecyc = exp_rv_q.pop_front();
                    if (result !== eres || i != ecyc || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL %s result got %0d@%0d busy%b want %0d@%0d busy0",
                                 name, result, i, busy, eres, ecyc);
                    end
                end
            end
            if (i == inj) begin
                start = 1'b1; len = 4'd1; wr_en = 1'b1; wr_sel = 1'b0;
                wr_addr = 3'd0; wr_data = 4'd7;
            end
        end
        checks++;
        if (exp_q.size() != 0 || exp_res_q.size() != 0 || rv_count != 1 || zero_viol != 0) begin
            errors++;
            $display("FAIL %s completion got missing_strobes %0d missing_results %0d pulses %0d zero_viol %0d want 0 0 1 0",
                     name, exp_q.size(), exp_res_q.size(), rv_count, zero_viol);
        end
        exp_q.delete(); exp_res_q.delete(); exp_rv_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        len = '0; skew_mode = '0; start = 1'b0; mac_clr = 1'b0; mac_force = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, va, vb, out_a, out_b, result, rv} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state got busy%b va%b vb%b a%h b%h res%0d rv%b want all 0",
                     busy, va, vb, out_a, out_b, result, rv);
        end
        reset = 1'b0;
    endtask

    task automatic test_paired;
        int a0 [4] = '{1, 2, -3, 4};
        int b0 [4] = '{2, -1, 2, 3};
        for (int j = 0; j < 4; j++) begin
            load(1'b0, j, a0[j]);
            load(1'b1, j, b0[j]);
        end
        push_expected(4, 2'b00);
        run("paired", 4, 2'b00, 0, 1'b0, 0);
    endtask

    task automatic test_skew;
        push_expected(4, 2'b01);
        run("skew_a_leads", 4, 2'b01, 0, 1'b0, 0);
        push_expected(4, 2'b10);
        run("skew_b_leads", 4, 2'b10, 0, 1'b0, 0);
        push_expected(4, 2'b00);
        run("skew_11_paired", 4, 2'b11, 0, 1'b0, 0);
    endtask

    task automatic test_len_edges;
        int a1 [4] = '{-2, 3, 0, -1};
        int b1 [4] = '{1, 1, 5, -4};
        push_expected(0, 2'b00);
        run("len_zero", 0, 2'b00, 0, 1'b0, 0);
        for (int j = 0; j < 4; j++) begin
            load(1'b0, 4 + j, a1[j]);
            load(1'b1, 4 + j, b1[j]);
        end
        push_expected(12, 2'b00);
        run("len_clamp", 12, 2'b00, 0, 1'b0, 0);
        push_expected(8, 2'b01);
        run("len8_skew", 8, 2'b01, 0, 1'b0, 0);
    endtask

    task automatic test_reset_midrun;
        int pulses;
        pulses = 0;
        @(negedge clk);
        len = 4'd4; skew_mode = 2'b00; start = 1'b1; mac_clr = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0; mac_clr = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, va, vb, out_a, out_b, result} !== 22'd0) begin
            errors++;
            $display("FAIL reset_midrun got busy%b va%b vb%b a%h b%h res%0d want all 0",
                     busy, va, vb, out_a, out_b, result);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rv) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_midrun_no_result got %0d pulses want 0", pulses);
        end
        push_expected(4, 2'b00);
        run("after_reset", 4, 2'b00, 0, 1'b0, 0);
    endtask

    task automatic test_same_cycle_write;
        ma[0] = -5;
        push_expected(4, 2'b00);
        run("start_with_write", 4, 2'b00, 0, 1'b1, -5);
    endtask

    task automatic test_full_negative;
        for (int j = 0; j < 8; j++) begin
            load(1'b0, j, -8);
            load(1'b1, j, -8);
        end
        push_expected(8, 2'b00);
        run("neg8_midrun_poke", 8, 2'b00, 4, 1'b0, 0);
        push_expected(8, 2'b10);
        run("neg8_banks_kept", 8, 2'b10, 0, 1'b0, 0);
    endtask

`ifdef MAC_FEEDER_CHECK_EN
    task automatic test_mismatch;
        int a0 [4] = '{1, 2, -3, 4};
        int b0 [4] = '{2, -1, 2, 3};
        for (int j = 0; j < 4; j++) begin
            load(1'b0, j, a0[j]);
            load(1'b1, j, b0[j]);
        end
        mac_force = 1'b1;
        push_expected(4, 2'b00);
        exp_res_q[exp_res_q.size()-1] = 11'd5;
        run("forced_mac", 4, 2'b00, 0, 1'b0, 0);
        mac_force = 1'b0;
        checks++;
        if (mismatch !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_set got %b want 1", mismatch);
        end
        push_expected(4, 2'b01);
        run("clean_after_mismatch", 4, 2'b01, 0, 1'b0, 0);
        checks++;
        if (mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_clear got %b want 0", mismatch);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_paired();
        test_skew();
        test_len_edges();
        test_reset_midrun();
        test_same_cycle_write();
        test_full_negative();
`ifdef MAC_FEEDER_CHECK_EN
        test_mismatch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
